// File: rtl/serial_feeder_1101_if.sv
// rtl/serial_feeder_1101_if.sv - word handshake and serial output bundle for serial_feeder_1101
interface serial_feeder_1101_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             x;
   logic             x_valid;
   logic             busy;
   logic [7:0]       words_sent;

   modport master (
      output din, din_valid,
      input  din_ready, x, x_valid, busy, words_sent
   );

   modport slave (
      input  din, din_valid,
      output din_ready, x, x_valid, busy, words_sent
   );
endinterface

// File: rtl/serial_feeder_1101.sv
// rtl/serial_feeder_1101.sv - gapless parallel-to-serial feeder for the 1101 detector
// SERIAL_LSB_FIRST_EN selects LSB-first order; MSB-first when undefined.
module serial_feeder_1101 #(
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 reset,
   serial_feeder_1101_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic [7:0]       words_q, words_d;
   logic             last_bit;
   logic             ready;
   logic             accept;
   logic             first_bit;

`ifdef SERIAL_LSB_FIRST_EN
   localparam int OUT_BIT = 0;
   assign sr_shift = {1'b0, sr_q[WIDTH-1:1]};
`else
   localparam int OUT_BIT = WIDTH - 1;
   assign sr_shift = {sr_q[WIDTH-2:0], 1'b0};
`endif

   assign first_bit = bus.din[OUT_BIT];
   assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
   assign accept    = bus.din_valid && ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT:   if (last_bit && !accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ready is held low during reset so no word can slip in on the release edge.
   always_comb begin
      ready    = reset && ((state_q == IDLE) || last_bit);
      bus.busy = (state_q == SHIFT);
   end

   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      words_d   = words_q + {7'd0, last_bit};
      if (accept) begin
         sr_d      = bus.din;
         cnt_d     = '0;
         x_d       = first_bit;
         x_valid_d = 1'b1;
      end else if ((state_q == SHIFT) && !last_bit) begin
         sr_d      = sr_shift;
         cnt_d     = cnt_q + 1'b1;
         x_d       = sr_shift[OUT_BIT];
         x_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sr_q      <= '0;
         cnt_q     <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         words_q   <= 8'd0;
      end else begin
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         words_q   <= words_d;
      end
   end

   assign bus.din_ready  = ready;
   assign bus.x          = x_q;
   assign bus.x_valid    = x_valid_q;
   assign bus.words_sent = words_q;
endmodule

// File: tb/tb_serial_feeder_1101.sv
// tb/tb_serial_feeder_1101.sv - directed self-checking bench for serial_feeder_1101
module tb_serial_feeder_1101;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   logic [7:0]  seq8;
   logic [15:0] seq16;

   serial_feeder_1101_if #(.WIDTH(8)) bus ();

   serial_feeder_1101 #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      reset         = 1'b0;
      bus.din_valid = 1'b1;
      bus.din       = 8'hFF;

      // reset held with a pending word
      repeat (3) @(negedge clk);
      chk("rst_x", {31'd0, bus.x}, 32'd0);
      chk("rst_x_valid", {31'd0, bus.x_valid}, 32'd0);
      chk("rst_din_ready", {31'd0, bus.din_ready}, 32'd0);
      chk("rst_words", {24'd0, bus.words_sent}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      reset         = 1'b1;
      bus.din_valid = 1'b0;
      #1;
      chk("idle_din_ready", {31'd0, bus.din_ready}, 32'd1);

      // single word; both orders produce send sequence 1101_0000
      @(negedge clk);
`ifdef SERIAL_LSB_FIRST_EN
      bus.din = 8'h0B;
`else
      bus.din = 8'hD0;
`endif
      seq8          = 8'b1101_0000;
      bus.din_valid = 1'b1;
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.din       = 8'h00;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("single_x[%0d]", k), {31'd0, bus.x}, {31'd0, seq8[7-k]});
         chk($sformatf("single_xv[%0d]", k), {31'd0, bus.x_valid}, 32'd1);
         @(negedge clk);
      end
      chk("single_end_x", {31'd0, bus.x}, 32'd0);
      chk("single_end_xv", {31'd0, bus.x_valid}, 32'd0);
      chk("single_words", {24'd0, bus.words_sent}, 32'd1);
      chk("single_end_busy", {31'd0, bus.busy}, 32'd0);

      // back-to-back A5 then 3C (palindromic, so order-independent)
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("b2b_pre_words", {24'd0, bus.words_sent}, 32'd0);
      bus.din       = 8'hA5;
      bus.din_valid = 1'b1;
      @(negedge clk);
      bus.din = 8'h3C;
      seq16   = 16'b1010_0101_0011_1100;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("b2b_x[%0d]", k), {31'd0, bus.x}, {31'd0, seq16[15-k]});
         chk($sformatf("b2b_xv[%0d]", k), {31'd0, bus.x_valid}, 32'd1);
         chk($sformatf("b2b_ready[%0d]", k), {31'd0, bus.din_ready}, ((k % 8) == 7) ? 32'd1 : 32'd0);
         if (k == 15) bus.din_valid = 1'b0;
         @(negedge clk);
      end
      chk("b2b_end_xv", {31'd0, bus.x_valid}, 32'd0);
      chk("b2b_words", {24'd0, bus.words_sent}, 32'd2);

      // reset after the third bit of FF abandons the word
      bus.din       = 8'hFF;
      bus.din_valid = 1'b1;
      @(negedge clk);
      bus.din_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_busy_before", {31'd0, bus.busy}, 32'd1);
      chk("mid_x_before", {31'd0, bus.x}, 32'd1);
      reset         = 1'b0;
      bus.din_valid = 1'b1;
      @(negedge clk);
      chk("mid_x", {31'd0, bus.x}, 32'd0);
      chk("mid_xv", {31'd0, bus.x_valid}, 32'd0);
      chk("mid_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_words", {24'd0, bus.words_sent}, 32'd0);
      chk("mid_ready", {31'd0, bus.din_ready}, 32'd0);
      @(negedge clk);
      reset         = 1'b1;
      bus.din_valid = 1'b0;
      @(negedge clk);
      chk("mid_no_accept_busy", {31'd0, bus.busy}, 32'd0);
      bus.din       = 8'h81;
      bus.din_valid = 1'b1;
      seq8          = 8'b1000_0001;
      @(negedge clk);
      bus.din_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("post_x[%0d]", k), {31'd0, bus.x}, {31'd0, seq8[7-k]});
         chk($sformatf("post_xv[%0d]", k), {31'd0, bus.x_valid}, 32'd1);
         @(negedge clk);
      end
      chk("post_words", {24'd0, bus.words_sent}, 32'd1);

      // counter wrap over 256 words
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int w = 1; w <= 256; w++) begin
         bus.din       = w[7:0];
         bus.din_valid = 1'b1;
         @(negedge clk);
         bus.din_valid = 1'b0;
         repeat (8) @(negedge clk);
         if (w == 255) chk("wrap_255", {24'd0, bus.words_sent}, 32'd255);
      end
      chk("wrap_0", {24'd0, bus.words_sent}, 32'd0);
      chk("wrap_idle_xv", {31'd0, bus.x_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
